// File: rtl/recog_pkg.sv
// ---------------------------------------------------------------------------
// recog_pkg
// Shared definitions for the handwritten-digit recognition session logic:
//   - geometry / code widths of the stroke grid and classifier result
//   - session FSM state encoding (enum plus plain 3-bit constants)
//   - touched(): raw panel coordinates -> "pen is on the panel"
// ---------------------------------------------------------------------------
package recog_pkg;

  localparam int GRID_X  = 12;  // stroke-grid columns
  localparam int GRID_Y  = 8;   // stroke-grid rows
  localparam int DIGIT_W = 4;   // classifier digit code width
  localparam int COORD_W = 12;  // raw touch-panel coordinate width
  localparam int STATE_W = 3;   // session state code width

  typedef enum logic [STATE_W-1:0] {
    SS_CLR   = 3'd0,
    SS_ARMED = 3'd1,
    SS_DRAW  = 3'd2,
    SS_REQ   = 3'd3,
    SS_WAIT  = 3'd4,
    SS_SHOW  = 3'd5
  } sess_state_t;

  // Plain constants so the state register can be a simple vector that can
  // also hold the unused codes 6/7 (which recover to CLR).
  localparam logic [STATE_W-1:0] ST_CLR   = SS_CLR;
  localparam logic [STATE_W-1:0] ST_ARMED = SS_ARMED;
  localparam logic [STATE_W-1:0] ST_DRAW  = SS_DRAW;
  localparam logic [STATE_W-1:0] ST_REQ   = SS_REQ;
  localparam logic [STATE_W-1:0] ST_WAIT  = SS_WAIT;
  localparam logic [STATE_W-1:0] ST_SHOW  = SS_SHOW;

  // The panel reports (0,0) when nothing touches it.
  function automatic logic touched(input logic [COORD_W-1:0] x,
                                   input logic [COORD_W-1:0] y);
    return (x | y) != '0;
  endfunction

endpackage

// File: rtl/touch_debounce.sv
// ---------------------------------------------------------------------------
// touch_debounce
// Detects a touch from raw panel coordinates and counts consecutive touched
// cycles while enabled. pen_down is high while the run has reached
// DEBOUNCE_N; any untouched cycle (or enable low) restarts the run.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   enable             count only while high (session is armed)
//   touch_x, touch_y   raw panel coordinates
//   touched            combinational "coordinates non-zero"
//   pen_down           debounced pen-down indication
// ---------------------------------------------------------------------------
module touch_debounce
  import recog_pkg::*;
#(
  parameter int DEBOUNCE_N = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [COORD_W-1:0] touch_x,
  input  logic [COORD_W-1:0] touch_y,
  output logic               touched_now,
  output logic               pen_down
);

  localparam int RUN_W = $clog2(DEBOUNCE_N + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DEBOUNCE_N);

  logic [RUN_W-1:0] run_reg;
  logic [RUN_W-1:0] run_next;

  assign touched_now = touched(touch_x, touch_y);

  // The run saturates at DEBOUNCE_N so a held touch cannot wrap it.
  always_comb begin
    run_next = run_reg;
    if (!enable || !touched_now) begin
      run_next = '0;
    end else if (run_reg != RUN_MAX) begin
      run_next = run_reg + RUN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_reg <= '0;
    end else begin
      run_reg <= run_next;
    end
  end

  assign pen_down = enable && (run_reg == RUN_MAX);

endmodule

// File: rtl/recog_session_ctrl.sv
// ---------------------------------------------------------------------------
// recog_session_ctrl
// Sequences one digit-recognition session: clear the stroke accumulator,
// wait for a debounced pen-down, capture strokes until a long pen-up gap,
// request classification (with timeout), show the digit, then clear again.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-low reset
//   i_touch_x, i_touch_y    raw panel coordinates (0,0 = no touch)
//   i_clear                 user abort, forces CLR from any other state
//   i_result_ready          classifier done (level)
//   i_result                classifier digit, sampled only in WAIT
//   o_acc_clr               one-cycle accumulator clear pulse
//   o_acc_start             accumulator capture enable (DRAW)
//   o_pls_check             classification request (WAIT and SHOW)
//   o_result                latched digit
//   o_result_valid          digit displayable (SHOW)
//   o_timeout_err           last request timed out; cleared with o_acc_clr
//   o_state                 current state code for debug/LEDs
// ---------------------------------------------------------------------------
module recog_session_ctrl
  import recog_pkg::*;
#(
  parameter int DEBOUNCE_N   = 4,
  parameter int PENUP_CYCLES = 25_000_000,
  parameter int RESULT_TO    = 1_000_000,
  parameter int SHOW_CYCLES  = 100_000_000,
  parameter int CNT_W        = 27
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [COORD_W-1:0] i_touch_x,
  input  logic [COORD_W-1:0] i_touch_y,
  input  logic               i_clear,
  input  logic               i_result_ready,
  input  logic [DIGIT_W-1:0] i_result,
  output logic               o_acc_clr,
  output logic               o_acc_start,
  output logic               o_pls_check,
  output logic [DIGIT_W-1:0] o_result,
  output logic               o_result_valid,
  output logic               o_timeout_err,
  output logic [STATE_W-1:0] o_state
);

  localparam logic [CNT_W-1:0] PENUP_LOAD  = CNT_W'(PENUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESULT_LOAD = CNT_W'(RESULT_TO - 1);
  localparam logic [CNT_W-1:0] SHOW_LOAD   = CNT_W'(SHOW_CYCLES - 1);

  logic [STATE_W-1:0] state_reg;
  logic [STATE_W-1:0] state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [CNT_W-1:0]   cnt_next;
  logic [CNT_W-1:0]   cnt_dec;
  logic               cnt_zero;
  logic               touch;
  logic               pen_down;
  logic               timeout_hit;

  touch_debounce #(
    .DEBOUNCE_N (DEBOUNCE_N)
  ) u_debounce (
    .clk         (i_clk),
    .rst_n       (i_rst),
    .enable      (state_reg == ST_ARMED),
    .touch_x     (i_touch_x),
    .touch_y     (i_touch_y),
    .touched_now (touch),
    .pen_down    (pen_down)
  );

  assign cnt_zero = (cnt_reg == '0);
  // Saturating decrement: the shared counter never wraps below zero.
  assign cnt_dec  = cnt_zero ? '0 : cnt_reg - CNT_W'(1);

  // Next-state logic. i_clear overrides everything except CLR itself.
  always_comb begin
    state_next  = state_reg;
    timeout_hit = 1'b0;
    case (state_reg)
      ST_CLR:   state_next = ST_ARMED;
      ST_ARMED: if (pen_down) state_next = ST_DRAW;
      ST_DRAW:  if (!touch && cnt_zero) state_next = ST_REQ;
      ST_REQ:   state_next = ST_WAIT;
      ST_WAIT: begin
        // Ready wins over a timeout falling in the same cycle.
        if (i_result_ready) begin
          state_next = ST_SHOW;
        end else if (cnt_zero) begin
          state_next  = ST_CLR;
          timeout_hit = 1'b1;
        end
      end
      ST_SHOW:  if (touch || cnt_zero) state_next = ST_CLR;
      default:  state_next = ST_CLR;
    endcase
    if (i_clear && (state_reg != ST_CLR)) begin
      state_next  = ST_CLR;
      timeout_hit = 1'b0;
    end
  end

  // Shared down-counter: loaded on entry to a timed state, then counts
  // down; in DRAW every touched cycle restarts the pen-up gap.
  always_comb begin
    cnt_next = cnt_reg;
    if (state_next != state_reg) begin
      case (state_next)
        ST_DRAW: cnt_next = PENUP_LOAD;
        ST_WAIT: cnt_next = RESULT_LOAD;
        ST_SHOW: cnt_next = SHOW_LOAD;
        default: cnt_next = '0;
      endcase
    end else begin
      case (state_reg)
        ST_DRAW: cnt_next = touch ? PENUP_LOAD : cnt_dec;
        ST_WAIT: cnt_next = cnt_dec;
        ST_SHOW: cnt_next = cnt_dec;
        default: cnt_next = '0;
      endcase
    end
  end

  // State, counter and all outputs are registered. Level outputs follow
  // the state being entered so they line up with o_state; the clear pulse
  // is issued on the edge that leaves CLR, which is also where the sticky
  // timeout flag is dropped.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg      <= ST_CLR;
      cnt_reg        <= '0;
      o_acc_clr      <= 1'b0;
      o_acc_start    <= 1'b0;
      o_pls_check    <= 1'b0;
      o_result       <= '0;
      o_result_valid <= 1'b0;
      o_timeout_err  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      o_acc_clr      <= (state_reg == ST_CLR);
      o_acc_start    <= (state_next == ST_DRAW);
      o_pls_check    <= (state_next == ST_WAIT) || (state_next == ST_SHOW);
      o_result_valid <= (state_next == ST_SHOW);
      if (state_reg == ST_CLR) begin
        o_timeout_err <= 1'b0;
      end else if (timeout_hit) begin
        o_timeout_err <= 1'b1;
      end
      // Out-of-range digits are passed through unchanged.
      if ((state_reg == ST_WAIT) && (state_next == ST_SHOW)) begin
        o_result <= i_result;
      end
    end
  end

  assign o_state = state_reg;

endmodule
